stepper_pulse_gen: RTL and testbench
====================================

# stepper_pulse_gen

Generates the step/direction pulse train for one tuner stepper motor from a signed move request. Its `step_out` drives the absolute step counter's `count_en` input. Each step is therefore one rising edge, and a high `step_out` holds off that counter's decrement timer. The block sits between the resonance-control move logic and the motor driver. It also closes the loop on the absolute step count: moves are inhibited while the count is at or above a configured limit.

## Interface
- `DIR_SETUP`, 16: clocks between `dir_out` update and first step edge.
- `MIN_PERIOD`, 4: smallest step period in clocks; smaller requests are raised to this.
- `clock` in 1: local bus clock, 125 MHz.
- `reset` in 1: synchronous, active-high.
- `move_req` in 1: start strobe; sampled only in IDLE.
- `move_steps` in 32: signed two's-complement step count; sign selects direction.
- `period` in 16: clocks per step, rising edge to rising edge.
- `abort` in 1: level; stop at the next step boundary.
- `abs_step` in 32: current absolute step count from the absolute step counter.
- `abs_limit` in 32: absolute step limit; 0 disables the check.
- `clr_fault` in 1: clears `limit_fault`.
- `step_out` out 1: step pulse to the driver and to the step counter's `count_en`.
- `dir_out` out 1: 1 = positive direction.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `aborted` out 1: valid with `done`; 1 if the move ended early.
- `limit_fault` out 1: sticky limit trip.
- `steps_remaining` out 32: unsigned steps not yet issued.

## Operation
- States: IDLE, SETUP, STEP_HI, STEP_LO, DONE.
- **IDLE → SETUP.** Taken when `move_req=1`, `limit_fault=0`, and `move_steps≠0`. On that edge the block latches:
  - `dir_out = ~move_steps[31]`;
  - `steps_remaining = |move_steps|`, unsigned, so −2^31 gives 2^31;
  - `per_q = max(period, MIN_PERIOD)`.
- **IDLE → DONE, no steps.** Taken when `move_req=1` and either `move_steps=0` or `limit_fault=1`. `aborted=1` only for the `limit_fault` case.
- **SETUP.** Lasts exactly `DIR_SETUP` cycles, then → STEP_HI. If `abort=1` during SETUP → DONE with `aborted=1` and no step.
- **STEP_HI.** `step_out=1` for `hi = per_q>>1` cycles. `steps_remaining` decrements on the entering edge.
- **STEP_LO.** `step_out=0` for `per_q − hi` cycles. On the last cycle, checks are taken in this priority:
  - `steps_remaining=0` → DONE, `aborted=0`;
  - limit: `abs_limit≠0` and `abs_step ≥ abs_limit` (unsigned) → set `limit_fault`, DONE, `aborted=1`;
  - `abort=1` → DONE, `aborted=1`;
  - otherwise → STEP_HI.
- **DONE.** One cycle: `done=1`, `aborted` valid, then → IDLE.
- **Mid-move inputs.** `period`, `move_steps`, and `move_req` are ignored outside IDLE.
- **Fault clearing.** `clr_fault` clears `limit_fault` in any state. A limit trip in the same cycle wins.
- **Aborted moves.** `steps_remaining` holds its residual value after an aborted move until the next accepted request.
- **Reset.** Synchronous reset in any state, including mid-pulse:
  - state = IDLE;
  - `step_out`, `dir_out`, `busy`, `done`, `aborted`, `limit_fault` = 0;
  - `steps_remaining` = 0.

## Timing
- All outputs are registered.
- Request at edge 0:
  - `busy` and `dir_out` valid in cycle 1;
  - SETUP occupies cycles 1..`DIR_SETUP`;
  - first `step_out` high in cycle `DIR_SETUP+1`.
- An N-step move at period P has `done` in cycle `DIR_SETUP + N·P + 1`. `busy` falls the cycle after that.
- Step count on `step_out` rising edges equals the decrements of `steps_remaining` exactly.
- No step is ever truncated by `abort` or the limit check.
- `dir_out` is stable from DIR_SETUP cycles before the first step until IDLE.
- A back-to-back `move_req` in the DONE cycle is ignored. It is accepted from the following IDLE cycle.

## Structure
- **Package `stepper_pkg`.**
  - State enumeration: IDLE, SETUP, STEP_HI, STEP_LO, DONE, 3-bit encoding.
  - Defaults for `DIR_SETUP` and `MIN_PERIOD`.
  - 32-bit step-count width constant.
- **Sub-module `step_phase_timer`.** A 16-bit loadable down-counter:
  - inputs: `load`, `load_val`;
  - output: `expired`, a one-cycle flag when the count reaches 1.
  - It is shared by SETUP, STEP_HI, and STEP_LO; the FSM stays in the top level.

## Test plan
- **Basic move.** `DIR_SETUP=16`, `move_steps=3`, `period=10`, req at cycle 0:
  - `dir_out=1` and `busy=1` at cycle 1;
  - `step_out` high in cycles 17–21, 27–31, 37–41;
  - `done=1`, `aborted=0` at cycle 47;
  - `steps_remaining` reads 2, 1, 0 after each rising edge.
- **Negative move, period clamp.** `move_steps=-2`, `period=1`:
  - `dir_out=0`;
  - period clamped to 4, giving `step_out` 2 high / 2 low;
  - exactly 2 pulses, then `done`.
- **Limit trip.** `abs_limit=100`, `abs_step` forced to 100 during the first step of a 5-step move:
  - exactly 1 pulse;
  - `limit_fault=1`, `done` with `aborted=1`, `steps_remaining=4`;
  - a next `move_req` gives `done`/`aborted` with no pulse until `clr_fault`.
- **Abort.** `abort` pulsed mid-STEP_HI of step 2 of 10:
  - step 2 completes its full width;
  - `done` with `aborted=1` and `steps_remaining=8`.
  - A second run with `abort` held during SETUP gives no pulse and `aborted=1`.
- **Zero and extreme counts.** `move_steps=0` gives `done` at cycle 1 with no pulse. `move_steps=32'h8000_0000` latches `steps_remaining=32'h8000_0000` and `dir_out=0`.
- **Reset mid-pulse.** `reset` asserted during STEP_HI:
  - next cycle all outputs are 0 and state is IDLE;
  - a new request afterwards runs normally.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper step/direction pulse generator.
package stepper_pkg;

    localparam int STEP_W         = 32;
    localparam int DIR_SETUP_DEF  = 16;
    localparam int MIN_PERIOD_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STEP_HI = 3'd2,
        S_STEP_LO = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Unsigned magnitude of a signed step count; -2^31 maps to 2^31.
    function automatic logic [STEP_W-1:0] abs_steps(input logic [STEP_W-1:0] s);
        return s[STEP_W-1] ? (~s + STEP_W'(1)) : s;
    endfunction

endpackage

// File: rtl/step_phase_timer.sv
// Loadable down-counter timing the SETUP, STEP_HI and STEP_LO phases.
module step_phase_timer (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        expired
);

    logic [15:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
        end
    end

    assign expired = (cnt == 16'd1);

endmodule

// File: rtl/stepper_pulse_gen.sv
// Step/direction pulse train generator for one tuner stepper motor,
// with an absolute-position limit interlock.
module stepper_pulse_gen
    import stepper_pkg::*;
#(
    parameter int DIR_SETUP  = DIR_SETUP_DEF,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              move_req,
    input  logic [STEP_W-1:0] move_steps,
    input  logic [15:0]       period,
    input  logic              abort,
    input  logic [STEP_W-1:0] abs_step,
    input  logic [STEP_W-1:0] abs_limit,
    input  logic              clr_fault,
    output logic              step_out,
    output logic              dir_out,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              limit_fault,
    output logic [STEP_W-1:0] steps_remaining
);

    state_t      state;
    logic [15:0] per_q;
    logic [15:0] hi_len;
    logic [15:0] lo_len;
    logic [15:0] per_clamped;
    logic        abort_q;
    logic        phase_end;
    logic        limit_hit;
    logic        tmr_load;
    logic [15:0] tmr_val;

    assign hi_len      = per_q >> 1;
    assign lo_len      = per_q - hi_len;
    assign per_clamped = (period < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD) : period;
    assign limit_hit   = (abs_limit != '0) && (abs_step >= abs_limit);

    // Reloading on a transition into DONE is harmless, so load is kept simple.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = 16'd0;
        unique case (state)
            S_IDLE: begin
                tmr_load = move_req;
                tmr_val  = 16'(DIR_SETUP);
            end
            S_SETUP: begin
                tmr_load = phase_end;
                tmr_val  = hi_len;
            end
            S_STEP_HI: begin
                tmr_load = phase_end;
                tmr_val  = lo_len;
            end
            S_STEP_LO: begin
                tmr_load = phase_end;
                tmr_val  = hi_len;
            end
            default: begin
                tmr_load = 1'b0;
                tmr_val  = 16'd0;
            end
        endcase
    end

    step_phase_timer u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (phase_end)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_IDLE;
            step_out        <= 1'b0;
            dir_out         <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            aborted         <= 1'b0;
            limit_fault     <= 1'b0;
            steps_remaining <= '0;
            per_q           <= 16'(MIN_PERIOD);
            abort_q         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr_fault) limit_fault <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    aborted <= 1'b0;
                    if (move_req) begin
                        busy <= 1'b1;
                        if (limit_fault || move_steps == '0) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            aborted <= limit_fault;
                        end else begin
                            state           <= S_SETUP;
                            dir_out         <= ~move_steps[STEP_W-1];
                            steps_remaining <= abs_steps(move_steps);
                            per_q           <= per_clamped;
                            abort_q         <= 1'b0;
                        end
                    end
                end
                S_SETUP: begin
                    if (abort) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (phase_end) begin
                        state           <= S_STEP_HI;
                        step_out        <= 1'b1;
                        steps_remaining <= steps_remaining - STEP_W'(1);
                    end
                end
                S_STEP_HI: begin
                    // A short abort pulse is remembered until the step boundary.
                    if (abort) abort_q <= 1'b1;
                    if (phase_end) begin
                        state    <= S_STEP_LO;
                        step_out <= 1'b0;
                    end
                end
                S_STEP_LO: begin
                    if (abort) abort_q <= 1'b1;
                    if (phase_end) begin
                        if (steps_remaining == '0) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            aborted <= 1'b0;
                        end else if (limit_hit) begin
                            limit_fault <= 1'b1;
                            state       <= S_DONE;
                            done        <= 1'b1;
                            aborted     <= 1'b1;
                        end else if (abort || abort_q) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            aborted <= 1'b1;
                        end else begin
                            state           <= S_STEP_HI;
                            step_out        <= 1'b1;
                            steps_remaining <= steps_remaining - STEP_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Self-checking bench: vector table, hand sequences and randomized moves
// against a timing model derived from the step/period arithmetic.
module tb_stepper_pulse_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic        move_req;
    logic [31:0] move_steps;
    logic [15:0] period;
    logic        abort;
    logic [31:0] abs_step;
    logic [31:0] abs_limit;
    logic        clr_fault;
    logic        step_out;
    logic        dir_out;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        limit_fault;
    logic [31:0] steps_remaining;

    int n_cmp  = 0;
    int n_fail = 0;

    stepper_pulse_gen dut (
        .clock           (clock),
        .reset           (reset),
        .move_req        (move_req),
        .move_steps      (move_steps),
        .period          (period),
        .abort           (abort),
        .abs_step        (abs_step),
        .abs_limit       (abs_limit),
        .clr_fault       (clr_fault),
        .step_out        (step_out),
        .dir_out         (dir_out),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .limit_fault     (limit_fault),
        .steps_remaining (steps_remaining)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam int DS = 16;

    typedef struct {
        int     steps;
        int     per;
        int     mode;
        int     exp_pulses;
        int     exp_done;
        bit     exp_ab;
        longint exp_rem;
        bit     exp_dir;
    } vec_t;

    // results of the last run_move
    int     r_pulses, r_done, r_bad, r_first;
    bit     r_ab, r_dir1, r_busy1, r_busy_after;
    longint r_rem;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int eff_period(input int p);
        return (p < 4) ? 4 : p;
    endfunction

    // mode 0 plain, 1 raise abs_step at first step, 2 abort pulse mid step 2,
    // 3 abort held from the request
    task automatic run_move(input int s, input int p, input int mode);
        int     cyc, hicnt, last_rise, pe;
        bit     prev;
        longint mag;
        pe  = eff_period(p);
        mag = (s < 0) ? -longint'(s) : longint'(s);
        r_pulses = 0; r_done = 0; r_bad = 0; r_first = 0;
        r_ab = 0; r_rem = 0; r_busy_after = 1;
        hicnt = 0; last_rise = 0; prev = 0;
        move_steps = s;
        period     = 16'(p);
        move_req   = 1'b1;
        if (mode == 3) abort = 1'b1;
        tick();
        move_req = 1'b0;
        cyc = 1;
        r_dir1  = dir_out;
        r_busy1 = busy;
        while (r_done == 0 && cyc < 3000) begin
            if (step_out && !prev) begin
                r_pulses++;
                if (r_pulses == 1) r_first = cyc;
                else if (cyc - last_rise != pe) r_bad++;
                last_rise = cyc;
                if (longint'(steps_remaining) != mag - r_pulses) r_bad++;
                hicnt = 0;
                if (mode == 1 && r_pulses == 1) abs_step = 32'd100;
            end
            if (step_out) hicnt++;
            if (!step_out && prev && hicnt != pe / 2) r_bad++;
            if (mode == 2) abort = (r_pulses == 2 && cyc == last_rise + 2);
            if (done) begin
                r_done = cyc;
                r_ab   = aborted;
                r_rem  = longint'(steps_remaining);
            end
            prev = step_out;
            if (r_done == 0) begin
                tick();
                cyc++;
            end
        end
        abort = 1'b0;
        if (r_done != 0) begin
            tick();
            r_busy_after = busy;
        end
    endtask

    task automatic check_run(input string tag, input int ep, input int ed,
                             input bit eab, input longint erem, input bit edir);
        check({tag, " done_cycle"}, r_done, ed);
        check({tag, " pulses"}, r_pulses, ep);
        check({tag, " aborted"}, r_ab, eab);
        check({tag, " remaining"}, r_rem, erem);
        check({tag, " dir"}, r_dir1, edir);
        check({tag, " busy1"}, r_busy1, 1);
        check({tag, " busy_after"}, r_busy_after, 0);
        check({tag, " shape_errs"}, r_bad, 0);
        if (ep > 0) check({tag, " first_rise"}, r_first, DS + 1);
    endtask

    vec_t vt[7];

    initial begin
        vt[0] = '{3, 10, 0, 3, 47, 0, 0, 1};
        vt[1] = '{-2, 1, 0, 2, 25, 0, 0, 0};
        vt[2] = '{0, 5, 0, 0, 1, 0, 0, 0};
        vt[3] = '{10, 6, 2, 2, 29, 1, 8, 1};
        vt[4] = '{4, 7, 3, 0, 2, 1, 4, 1};
        vt[5] = '{1, 9, 0, 1, 26, 0, 0, 1};
        vt[6] = '{-1, 4, 0, 1, 21, 0, 0, 0};

        reset = 1'b1; move_req = 1'b0; move_steps = '0; period = '0;
        abort = 1'b0; abs_step = '0; abs_limit = '0; clr_fault = 1'b0;
        repeat (3) tick();
        check("rst step_out", step_out, 0);
        check("rst dir_out", dir_out, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst aborted", aborted, 0);
        check("rst limit_fault", limit_fault, 0);
        check("rst remaining", steps_remaining, 0);
        reset = 1'b0;
        tick();

        // back-to-back request held through DONE
        move_steps = '0;
        move_req   = 1'b1;
        tick();
        check("b2b done c1", done, 1);
        tick();
        check("b2b done c2", done, 0);
        check("b2b busy c2", busy, 0);
        tick();
        check("b2b done c3", done, 1);
        move_req = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 7; i++) begin
            run_move(vt[i].steps, vt[i].per, vt[i].mode);
            check_run($sformatf("vec%0d", i), vt[i].exp_pulses, vt[i].exp_done,
                      vt[i].exp_ab, vt[i].exp_rem, vt[i].exp_dir);
            tick();
        end

        // limit trip during first step of a 5-step move
        abs_limit = 32'd100;
        abs_step  = 32'd0;
        run_move(5, 10, 1);
        check_run("limit", 1, DS + 10 + 1, 1, 4, 1);
        check("limit fault set", limit_fault, 1);
        run_move(3, 10, 0);
        check("limit blocked done", r_done, 1);
        check("limit blocked pulses", r_pulses, 0);
        check("limit blocked aborted", r_ab, 1);
        check("limit blocked remaining", r_rem, 4);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        check("fault cleared", limit_fault, 0);
        abs_limit = '0;
        abs_step  = '0;
        tick();

        // most negative count, then reset in the middle of the first pulse
        move_steps = 32'h8000_0000;
        period     = 16'd4;
        move_req   = 1'b1;
        tick();
        move_req = 1'b0;
        check("ext dir", dir_out, 0);
        check("ext remaining", steps_remaining, 64'h8000_0000);
        begin
            int w = 0;
            while (!step_out && w < 40) begin
                tick();
                w++;
            end
        end
        check("ext step high", step_out, 1);
        check("ext remaining after step", steps_remaining, 64'h7FFF_FFFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst step_out", step_out, 0);
        check("midrst busy", busy, 0);
        check("midrst remaining", steps_remaining, 0);
        check("midrst dir", dir_out, 0);
        check("midrst done", {done, aborted, limit_fault}, 0);
        tick();
        run_move(2, 5, 0);
        check_run("post_rst", 2, DS + 2 * 5 + 1, 0, 0, 1);
        tick();

        // randomized moves against the arithmetic timing model
        for (int k = 0; k < 10; k++) begin
            int n, p, s;
            n = int'($urandom_range(1, 5));
            p = int'($urandom_range(0, 12));
            s = $urandom_range(0, 1) ? -n : n;
            abs_step  = $urandom_range(0, 1000);
            abs_limit = $urandom_range(0, 1) ? 32'd0 : 32'hFFFF_FFFF;
            run_move(s, p, 0);
            check_run($sformatf("rnd%0d", k), n, DS + n * eff_period(p) + 1,
                      0, 0, s > 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
